// File: rtl/rate_ctrl_pkg.sv
// Shared types and constants for the stopwatch rate controller: mode/speed
// encodings, mode LED patterns and default speed-request scan codes.
package rate_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_HOLD = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        SPD_SLOW = 2'd0,
        SPD_NORM = 2'd1,
        SPD_FAST = 2'd2
    } speed_t;

    localparam logic [15:0] LED_IDLE = 16'hF000;
    localparam logic [15:0] LED_RUN  = 16'h0F00;
    localparam logic [15:0] LED_HOLD = 16'h00F0;

    localparam logic [8:0] KEY_FAST_DEF = 9'h069;
    localparam logic [8:0] KEY_SLOW_DEF = 9'h072;

    function automatic logic [15:0] led_for(input mode_t m);
        case (m)
            MODE_RUN:  led_for = LED_RUN;
            MODE_HOLD: led_for = LED_HOLD;
            default:   led_for = LED_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rate_prescaler.sv
// Shared tick prescaler: one up-counter whose terminal value follows the
// current speed; restarts on clear or speed change, freezes on saturation.
module rate_prescaler
    import rate_ctrl_pkg::*;
#(
    parameter int DIV_SLOW = 27,
    parameter int DIV_NORM = 25,
    parameter int DIV_FAST = 21
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   active,
    input  logic   sat,
    input  logic   restart,
    input  speed_t speed,
    output logic   tick
);

    localparam logic [DIV_SLOW-1:0] ONES      = '1;
    localparam logic [DIV_SLOW-1:0] TERM_SLOW = ONES;
    localparam logic [DIV_SLOW-1:0] TERM_NORM = ONES >> (DIV_SLOW - DIV_NORM);
    localparam logic [DIV_SLOW-1:0] TERM_FAST = ONES >> (DIV_SLOW - DIV_FAST);

    logic [DIV_SLOW-1:0] cnt_q, cnt_d;
    logic [DIV_SLOW-1:0] term;
    logic                tick_q, tick_d;

    always_comb begin
        case (speed)
            SPD_SLOW: term = TERM_SLOW;
            SPD_FAST: term = TERM_FAST;
            default:  term = TERM_NORM;
        endcase
    end

    // Restart outranks expiry so a tick never coincides with a clear.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (restart || !active) begin
            cnt_d = '0;
        end else if (!sat) begin
            if (cnt_q == term) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/count_rate_ctrl.sv
// Stopwatch sequencer: IDLE/RUN/HOLD mode FSM, speed request arbitration,
// clear pulse and mode LEDs, driving the shared tick prescaler.
module count_rate_ctrl
    import rate_ctrl_pkg::*;
#(
    parameter int         DIV_SLOW = 27,
    parameter int         DIV_NORM = 25,
    parameter int         DIV_FAST = 21,
    parameter logic [8:0] KEY_FAST = KEY_FAST_DEF,
    parameter logic [8:0] KEY_SLOW = KEY_SLOW_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_pulse,
    input  logic        up_pulse,
    input  logic        down_pulse,
    input  logic        up_held,
    input  logic        down_held,
    input  logic        key_valid,
    input  logic [8:0]  last_change,
    input  logic        key_press,
    input  logic        fast_key_dn,
    input  logic        slow_key_dn,
    input  logic        cnt_sat,
    output logic [1:0]  mode,
    output logic [1:0]  speed,
    output logic        tick,
    output logic        clear,
    output logic [15:0] led
);

    mode_t       mode_q, mode_d;
    speed_t      speed_q, speed_d;
    logic        clear_q, clear_d;
    logic [15:0] led_q, led_d;
    logic        fast_req, slow_req;
    logic        restart;

    assign fast_req = up_pulse   | (key_valid & key_press & (last_change == KEY_FAST));
    assign slow_req = down_pulse | (key_valid & key_press & (last_change == KEY_SLOW));

    // A mode advance swallows any coincident speed request; the new mode's
    // speed rule takes over one cycle after entry.
    always_comb begin
        mode_d  = mode_q;
        speed_d = speed_q;
        clear_d = 1'b0;
        if (en_pulse) begin
            clear_d = 1'b1;
            case (mode_q)
                MODE_IDLE: mode_d = MODE_RUN;
                MODE_RUN:  mode_d = MODE_HOLD;
                default:   mode_d = MODE_IDLE;
            endcase
            if (mode_d == MODE_IDLE) begin
                speed_d = SPD_NORM;
            end
        end else begin
            case (mode_q)
                MODE_RUN: begin
                    if (slow_req) begin
                        speed_d = SPD_SLOW;
                    end else if (fast_req) begin
                        speed_d = SPD_FAST;
                    end
                end
                MODE_HOLD: begin
                    if (down_held | slow_key_dn) begin
                        speed_d = SPD_SLOW;
                    end else if (up_held | fast_key_dn) begin
                        speed_d = SPD_FAST;
                    end else begin
                        speed_d = SPD_NORM;
                    end
                end
                default: speed_d = SPD_NORM;
            endcase
        end
        led_d = led_for(mode_d);
    end

    assign restart = clear_d | (speed_d != speed_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q  <= MODE_IDLE;
            speed_q <= SPD_NORM;
            clear_q <= 1'b0;
            led_q   <= LED_IDLE;
        end else begin
            mode_q  <= mode_d;
            speed_q <= speed_d;
            clear_q <= clear_d;
            led_q   <= led_d;
        end
    end

    rate_prescaler #(
        .DIV_SLOW (DIV_SLOW),
        .DIV_NORM (DIV_NORM),
        .DIV_FAST (DIV_FAST)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .active  (mode_q != MODE_IDLE),
        .sat     (cnt_sat),
        .restart (restart),
        .speed   (speed_q),
        .tick    (tick)
    );

    assign mode  = mode_q;
    assign speed = speed_q;
    assign clear = clear_q;
    assign led   = led_q;

endmodule

// File: tb/tb_count_rate_ctrl.sv
// Directed bench for count_rate_ctrl with short prescaler periods (64/16/4).
module tb_count_rate_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_pulse, up_pulse, down_pulse, up_held, down_held;
    logic        key_valid, key_press, fast_key_dn, slow_key_dn, cnt_sat;
    logic [8:0]  last_change;
    logic [1:0]  mode, speed;
    logic        tick, clear;
    logic [15:0] led;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    count_rate_ctrl #(
        .DIV_SLOW (6),
        .DIV_NORM (4),
        .DIV_FAST (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_pulse    (en_pulse),
        .up_pulse    (up_pulse),
        .down_pulse  (down_pulse),
        .up_held     (up_held),
        .down_held   (down_held),
        .key_valid   (key_valid),
        .last_change (last_change),
        .key_press   (key_press),
        .fast_key_dn (fast_key_dn),
        .slow_key_dn (slow_key_dn),
        .cnt_sat     (cnt_sat),
        .mode        (mode),
        .speed       (speed),
        .tick        (tick),
        .clear       (clear),
        .led         (led)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles; counts ticks and cycles whose tick differs from the
    // expected period pattern (period 0 means no tick is expected).
    task automatic run_ticks(input int n, input int period, output int ticks, output int bad);
        ticks = 0;
        bad   = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            if (tick === 1'b1) ticks++;
            if (tick !== ((period != 0) && (k % period == 0))) bad++;
            if (tick === 1'b1 && clear === 1'b1) bad++;
        end
    endtask

    task automatic test_reset();
        int ticks, bad;
        rst = 1'b0;
        step();
        step();
        total_cnt++;
        if (mode !== 2'd0) $display("FAIL reset_mode got=%0d exp=0", mode); else pass_cnt++;
        total_cnt++;
        if (speed !== 2'd1) $display("FAIL reset_speed got=%0d exp=1", speed); else pass_cnt++;
        total_cnt++;
        if (led !== 16'hF000) $display("FAIL reset_led got=%h exp=f000", led); else pass_cnt++;
        total_cnt++;
        if (tick !== 1'b0 || clear !== 1'b0)
            $display("FAIL reset_tick_clear got=%b%b exp=00", tick, clear);
        else pass_cnt++;
        rst = 1'b1;
        run_ticks(100, 0, ticks, bad);
        total_cnt++;
        if (ticks != 0 || mode !== 2'd0)
            $display("FAIL idle_no_tick got ticks=%0d mode=%0d exp ticks=0 mode=0", ticks, mode);
        else pass_cnt++;
    endtask

    task automatic test_run_norm();
        int ticks, bad;
        en_pulse = 1'b1;
        step();
        en_pulse = 1'b0;
        total_cnt++;
        if (clear !== 1'b1 || mode !== 2'd1 || led !== 16'h0F00)
            $display("FAIL enter_run got clear=%b mode=%0d led=%h exp clear=1 mode=1 led=0f00", clear, mode, led);
        else pass_cnt++;
        run_ticks(48, 16, ticks, bad);
        total_cnt++;
        if (ticks != 3 || bad != 0)
            $display("FAIL run_norm_period got ticks=%0d bad=%0d exp ticks=3 bad=0", ticks, bad);
        else pass_cnt++;
    endtask

    task automatic test_run_speed();
        int ticks, bad;
        key_valid = 1'b1; key_press = 1'b1; last_change = 9'h069;
        step();
        key_valid = 1'b0; key_press = 1'b0; last_change = 9'h000;
        total_cnt++;
        if (speed !== 2'd2) $display("FAIL run_key_fast got=%0d exp=2", speed); else pass_cnt++;
        run_ticks(12, 4, ticks, bad);
        total_cnt++;
        if (ticks != 3 || bad != 0 || speed !== 2'd2)
            $display("FAIL run_fast_period got ticks=%0d bad=%0d speed=%0d exp 3/0/2", ticks, bad, speed);
        else pass_cnt++;
        up_pulse = 1'b1; down_pulse = 1'b1;
        step();
        up_pulse = 1'b0; down_pulse = 1'b0;
        total_cnt++;
        if (speed !== 2'd0) $display("FAIL run_slow_wins got=%0d exp=0", speed); else pass_cnt++;
        run_ticks(128, 64, ticks, bad);
        total_cnt++;
        if (ticks != 2 || bad != 0)
            $display("FAIL run_slow_period got ticks=%0d bad=%0d exp ticks=2 bad=0", ticks, bad);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        int ticks, bad;
        en_pulse = 1'b1;
        step();
        en_pulse = 1'b0;
        total_cnt++;
        if (clear !== 1'b1 || mode !== 2'd2 || led !== 16'h00F0 || speed !== 2'd0)
            $display("FAIL enter_hold got clear=%b mode=%0d led=%h speed=%0d exp 1/2/00f0/0", clear, mode, led, speed);
        else pass_cnt++;
        fast_key_dn = 1'b1;
        step();
        total_cnt++;
        if (speed !== 2'd2) $display("FAIL hold_fast got=%0d exp=2", speed); else pass_cnt++;
        run_ticks(20, 4, ticks, bad);
        total_cnt++;
        if (ticks != 5 || bad != 0)
            $display("FAIL hold_fast_ticks got ticks=%0d bad=%0d exp ticks=5 bad=0", ticks, bad);
        else pass_cnt++;
        fast_key_dn = 1'b0;
        step();
        total_cnt++;
        if (speed !== 2'd1) $display("FAIL hold_release got=%0d exp=1", speed); else pass_cnt++;
        up_held = 1'b1; down_held = 1'b1;
        step();
        total_cnt++;
        if (speed !== 2'd0) $display("FAIL hold_both got=%0d exp=0", speed); else pass_cnt++;
        up_held = 1'b0; down_held = 1'b0;
        step();
        total_cnt++;
        if (speed !== 2'd1) $display("FAIL hold_norm_again got=%0d exp=1", speed); else pass_cnt++;
    endtask

    task automatic test_sat_and_expiry();
        int ticks, bad;
        cnt_sat = 1'b1;
        run_ticks(40, 0, ticks, bad);
        total_cnt++;
        if (ticks != 0) $display("FAIL sat_no_tick got=%0d exp=0", ticks); else pass_cnt++;
        cnt_sat = 1'b0;
        run_ticks(15, 0, ticks, bad);
        total_cnt++;
        if (ticks != 0) $display("FAIL sat_frozen_resume got=%0d exp=0", ticks); else pass_cnt++;
        en_pulse = 1'b1;
        step();
        en_pulse = 1'b0;
        total_cnt++;
        if (clear !== 1'b1 || tick !== 1'b0 || mode !== 2'd0 || speed !== 2'd1 || led !== 16'hF000)
            $display("FAIL expiry_vs_en got clear=%b tick=%b mode=%0d speed=%0d exp 1/0/0/1", clear, tick, mode, speed);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back_reset();
        int ticks, bad;
        en_pulse = 1'b1; up_pulse = 1'b1;
        step();
        en_pulse = 1'b0; up_pulse = 1'b0;
        total_cnt++;
        if (mode !== 2'd1 || speed !== 2'd1)
            $display("FAIL en_beats_req got mode=%0d speed=%0d exp mode=1 speed=1", mode, speed);
        else pass_cnt++;
        step();
        total_cnt++;
        if (speed !== 2'd1 || clear !== 1'b0)
            $display("FAIL req_dropped got speed=%0d clear=%b exp speed=1 clear=0", speed, clear);
        else pass_cnt++;
        run_ticks(13, 0, ticks, bad);
        rst = 1'b0;
        step();
        total_cnt++;
        if (mode !== 2'd0 || tick !== 1'b0 || led !== 16'hF000 || speed !== 2'd1)
            $display("FAIL mid_reset got mode=%0d tick=%b led=%h speed=%0d exp 0/0/f000/1", mode, tick, led, speed);
        else pass_cnt++;
        rst = 1'b1;
        run_ticks(20, 0, ticks, bad);
        total_cnt++;
        if (ticks != 0 || mode !== 2'd0)
            $display("FAIL post_reset_no_tick got ticks=%0d mode=%0d exp 0/0", ticks, mode);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b0;
        en_pulse = 1'b0; up_pulse = 1'b0; down_pulse = 1'b0;
        up_held = 1'b0; down_held = 1'b0;
        key_valid = 1'b0; key_press = 1'b0; last_change = 9'h000;
        fast_key_dn = 1'b0; slow_key_dn = 1'b0; cnt_sat = 1'b0;
        test_reset();
        test_run_norm();
        test_run_speed();
        test_hold();
        test_sat_and_expiry();
        test_back_to_back_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
